hypercorex_inst_loop_fetch: RTL and testbench
=============================================

Name: hypercorex_inst_loop_fetch

Overview:
- Parametrised instruction memory and fetch sequencer for the hypercorex core.
- Holds a program of 32-bit hypercorex instructions, programmed over a write port.
- Issues instructions one per cycle over a valid/ready handshake to the decoder.
- Supports up to NumLoops nested hardware loops with independent start/end addresses and iteration counts; previous generation was a flat, fixed opcode list with no sequencing.

Parameters:
- InstWidth, 32, instruction word width.
- InstDepth, 64, instruction memory entries; AddrWidth = clog2(InstDepth).
- NumLoops, 3, nested loop levels; level 0 is innermost.
- LoopCntWidth, 10, width of per-level iteration counters.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- enable_i  in  1  start/run request, level-sensitive.
- clr_i  in  1  synchronous return to IDLE; clears PC and counters; memory contents kept.
- inst_wr_en_i  in  1  program write strobe.
- inst_wr_addr_i  in  AddrWidth  write address.
- inst_wr_data_i  in  InstWidth  write data.
- loop_mode_i  in  clog2(NumLoops+1)  number of active loop levels, 0..NumLoops.
- loop_start_addr_i  in  NumLoops*AddrWidth  per-level jump-back address.
- loop_end_addr_i  in  NumLoops*AddrWidth  per-level last loop-body address.
- loop_count_i  in  NumLoops*LoopCntWidth  per-level iteration count; 0 is treated as 1.
- prog_end_addr_i  in  AddrWidth  last program address.
- inst_code_o  out  InstWidth  issued instruction.
- inst_valid_o  out  1  instruction valid.
- inst_ready_i  in  1  decoder accepts.
- inst_pc_o  out  AddrWidth  address of inst_code_o.
- busy_o  out  1  in RUN.
- program_done_o  out  1  in DONE.

Behaviour:
- Reset: state IDLE; PC=0; all loop counters 0. Outputs inst_valid_o=0, inst_code_o=0, inst_pc_o=0, busy_o=0, program_done_o=0.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN when enable_i=1: loads inst_code_o=mem[0], inst_pc_o=0, inst_valid_o=1 at the next edge (1-cycle latency).
  - RUN -> DONE on handshake of the instruction at prog_end_addr_i when no loop jumps: inst_valid_o=0, program_done_o=1 next cycle.
  - DONE -> IDLE when enable_i=0 or clr_i=1.
  - clr_i from any state -> IDLE next cycle; all outputs return to reset values; clr_i overrides enable_i.
- Config inputs (loop_*, prog_end_addr_i) are sampled continuously and must be stable while busy_o=1; changing them in RUN is unsupported.
- Handshake:
  - Transfer occurs when inst_valid_o & inst_ready_i.
  - While valid and not ready, inst_code_o and inst_pc_o hold stable.
  - On transfer, next_pc is computed and mem[next_pc] is registered, so throughput is 1 instruction/cycle with no bubbles.
  - Memory read is combinational from a flop array; output is registered.
- next_pc on transfer at address pc: scan levels k=0..loop_mode_i-1.
  - If loop_end[k]==pc and cnt[k] < max(loop_count[k],1)-1: cnt[k]++, next_pc=loop_start[k]; stop scan.
  - If loop_end[k]==pc and count is exhausted: cnt[k]=0; continue scan.
  - If no level jumps: next_pc=pc+1.
  - Inactive levels (k >= loop_mode_i) are ignored.
- Shared end addresses: inner exhausted levels reset while the outer level jumps, giving correct nested repetition.
- PC wrap: if no jump and pc==InstDepth-1 without reaching prog_end_addr_i, next_pc wraps to 0; this is legal but unintended.
- Writes:
  - Accepted only when state is IDLE or DONE; ignored in RUN.
  - A write to an address in the same cycle as that address is read in IDLE is not visible until the next cycle.
- Reset mid-RUN: immediate return to reset values; memory contents are undefined after rst_i (not cleared).

Decomposition:
- Package hypercorex_inst_loop_pkg:
  - state enum (IDLE/RUN/DONE);
  - default parameter constants;
  - helper function for loop-count-zero normalisation.
- Sub-module hypercorex_inst_mem: write-port flop array with combinational read, parametrised InstWidth/InstDepth.
- Sequencer, loop counters and output register live in the top module.

Test Plan:
- Linear run: write 0xA0..0xA4 to addr 0..4, prog_end=4, loop_mode=0, ready=1 -> pcs 0,1,2,3,4 on consecutive cycles, then program_done_o=1 next cycle.
- Single loop: start=1, end=2, count=3, prog_end=3 -> pc sequence 0,1,2,1,2,1,2,3, then DONE.
- Nested shared end: L0 start=2, end=3, count=2; L1 start=1, end=3, count=2; prog_end=3 -> pc sequence 0,1,2,3,2,3,1,2,3,2,3.
- Backpressure: ready toggles 1,0,0,1 -> inst_code_o/inst_pc_o stable while not ready; no instruction skipped or duplicated.
- Count 0 and writes in RUN: count=0 behaves as count=1 (no repeat); a write during RUN leaves mem unchanged on readback.
- Reset/clear: assert rst_i mid-loop -> all outputs 0 the same cycle; assert clr_i with enable_i=1 -> IDLE with valid=0 next cycle; re-enable restarts at pc 0 with counters 0.

Source files
------------

// File: rtl/hypercorex_inst_loop_pkg.sv
// Shared types, default sizing and loop helpers for the hypercorex loop fetch unit.
package hypercorex_inst_loop_pkg;

    localparam int unsigned DefaultInstWidth    = 32;
    localparam int unsigned DefaultInstDepth    = 64;
    localparam int unsigned DefaultNumLoops     = 3;
    localparam int unsigned DefaultLoopCntWidth = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } loop_fetch_state_e;

    // Index of the final iteration; a programmed count of 0 runs the body once.
    function automatic logic [31:0] loop_last_iter(input logic [31:0] count);
        return (count == '0) ? '0 : count - 32'd1;
    endfunction

endpackage

// File: rtl/hypercorex_inst_mem.sv
// Instruction store: flop array with a single write port and combinational read.
module hypercorex_inst_mem
    import hypercorex_inst_loop_pkg::*;
#(
    parameter int unsigned InstWidth = DefaultInstWidth,
    parameter int unsigned InstDepth = DefaultInstDepth,
    localparam int unsigned AddrWidth = $clog2(InstDepth)
) (
    input  logic                 clk_i,
    input  logic                 wr_en_i,
    input  logic [AddrWidth-1:0] wr_addr_i,
    input  logic [InstWidth-1:0] wr_data_i,
    input  logic [AddrWidth-1:0] rd_addr_i,
    output logic [InstWidth-1:0] rd_data_o
);

    logic [InstWidth-1:0] mem [InstDepth];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem[rd_addr_i];

endmodule

// File: rtl/hypercorex_inst_loop_fetch.sv
// Instruction fetch sequencer with nested hardware loops and a valid/ready issue port.
module hypercorex_inst_loop_fetch
    import hypercorex_inst_loop_pkg::*;
#(
    parameter int unsigned InstWidth    = DefaultInstWidth,
    parameter int unsigned InstDepth    = DefaultInstDepth,
    parameter int unsigned NumLoops     = DefaultNumLoops,
    parameter int unsigned LoopCntWidth = DefaultLoopCntWidth,
    localparam int unsigned AddrWidth   = $clog2(InstDepth),
    localparam int unsigned ModeWidth   = $clog2(NumLoops + 1)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             enable_i,
    input  logic                             clr_i,
    input  logic                             inst_wr_en_i,
    input  logic [AddrWidth-1:0]             inst_wr_addr_i,
    input  logic [InstWidth-1:0]             inst_wr_data_i,
    input  logic [ModeWidth-1:0]             loop_mode_i,
    input  logic [NumLoops*AddrWidth-1:0]    loop_start_addr_i,
    input  logic [NumLoops*AddrWidth-1:0]    loop_end_addr_i,
    input  logic [NumLoops*LoopCntWidth-1:0] loop_count_i,
    input  logic [AddrWidth-1:0]             prog_end_addr_i,
    output logic [InstWidth-1:0]             inst_code_o,
    output logic                             inst_valid_o,
    input  logic                             inst_ready_i,
    output logic [AddrWidth-1:0]             inst_pc_o,
    output logic                             busy_o,
    output logic                             program_done_o
);

    loop_fetch_state_e state;

    logic [NumLoops-1:0][LoopCntWidth-1:0] cnt;
    logic [NumLoops-1:0][LoopCntWidth-1:0] cnt_next;
    logic [AddrWidth-1:0]                  next_pc;
    logic                                  jump;
    logic [AddrWidth-1:0]                  rd_addr;
    logic [InstWidth-1:0]                  rd_data;
    logic                                  xfer;

    assign xfer    = inst_valid_o & inst_ready_i;
    assign rd_addr = (state == ST_RUN) ? next_pc : '0;
    assign busy_o         = (state == ST_RUN);
    assign program_done_o = (state == ST_DONE);

    hypercorex_inst_mem #(
        .InstWidth (InstWidth),
        .InstDepth (InstDepth)
    ) u_inst_mem (
        .clk_i     (clk_i),
        .wr_en_i   (inst_wr_en_i && (state != ST_RUN)),
        .wr_addr_i (inst_wr_addr_i),
        .wr_data_i (inst_wr_data_i),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    // Innermost-first scan: exhausted levels reset and defer to the next outer level.
    always_comb begin
        jump     = 1'b0;
        cnt_next = cnt;
        next_pc  = (inst_pc_o == AddrWidth'(InstDepth - 1)) ? '0 : inst_pc_o + AddrWidth'(1);
        for (int unsigned k = 0; k < NumLoops; k++) begin
            if (!jump && (k < 32'(loop_mode_i)) &&
                (loop_end_addr_i[k*AddrWidth +: AddrWidth] == inst_pc_o)) begin
                if (32'(cnt[k]) < loop_last_iter(32'(loop_count_i[k*LoopCntWidth +: LoopCntWidth]))) begin
                    cnt_next[k] = cnt[k] + LoopCntWidth'(1);
                    next_pc     = loop_start_addr_i[k*AddrWidth +: AddrWidth];
                    jump        = 1'b1;
                end else begin
                    cnt_next[k] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            inst_code_o  <= '0;
            inst_pc_o    <= '0;
            inst_valid_o <= 1'b0;
        end else if (clr_i) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            inst_code_o  <= '0;
            inst_pc_o    <= '0;
            inst_valid_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable_i) begin
                        state        <= ST_RUN;
                        cnt          <= '0;
                        inst_code_o  <= rd_data;
                        inst_pc_o    <= '0;
                        inst_valid_o <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (xfer) begin
                        cnt <= cnt_next;
                        if (!jump && (inst_pc_o == prog_end_addr_i)) begin
                            state        <= ST_DONE;
                            inst_valid_o <= 1'b0;
                        end else begin
                            inst_pc_o   <= next_pc;
                            inst_code_o <= rd_data;
                        end
                    end
                end
                ST_DONE: begin
                    if (!enable_i) begin
                        state       <= ST_IDLE;
                        cnt         <= '0;
                        inst_code_o <= '0;
                        inst_pc_o   <= '0;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    inst_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hypercorex_inst_loop_fetch.sv
// Scoreboard bench for hypercorex_inst_loop_fetch: directed pc sequences, monitor-side comparison.
module tb_hypercorex_inst_loop_fetch;

    localparam int unsigned IW = 32;
    localparam int unsigned AW = 6;
    localparam int unsigned NL = 3;
    localparam int unsigned CW = 10;

    typedef struct {
        logic [AW-1:0] pc;
        logic [IW-1:0] code;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             enable = 1'b0;
    logic             clr = 1'b0;
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [IW-1:0]    wr_data = '0;
    logic [1:0]       loop_mode = '0;
    logic [NL*AW-1:0] loop_start = '0;
    logic [NL*AW-1:0] loop_end = '0;
    logic [NL*CW-1:0] loop_count = '0;
    logic [AW-1:0]    prog_end = '0;
    logic [IW-1:0]    inst_code;
    logic             inst_valid;
    logic             inst_ready = 1'b0;
    logic [AW-1:0]    inst_pc;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_xfer_edge = 0;
    exp_t exp_q[$];
    logic [IW-1:0] shadow [64];

    hypercorex_inst_loop_fetch #(
        .InstWidth    (IW),
        .InstDepth    (64),
        .NumLoops     (NL),
        .LoopCntWidth (CW)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .enable_i          (enable),
        .clr_i             (clr),
        .inst_wr_en_i      (wr_en),
        .inst_wr_addr_i    (wr_addr),
        .inst_wr_data_i    (wr_data),
        .loop_mode_i       (loop_mode),
        .loop_start_addr_i (loop_start),
        .loop_end_addr_i   (loop_end),
        .loop_count_i      (loop_count),
        .prog_end_addr_i   (prog_end),
        .inst_code_o       (inst_code),
        .inst_valid_o      (inst_valid),
        .inst_ready_i      (inst_ready),
        .inst_pc_o         (inst_pc),
        .busy_o            (busy),
        .program_done_o    (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectation on every handshake, checks hold during stalls.
    logic          stalled = 1'b0;
    logic [AW-1:0] held_pc;
    logic [IW-1:0] held_code;
    always @(negedge clk) begin
        if (!rst && inst_valid) begin
            if (stalled) check("hold", {inst_pc, inst_code}, {held_pc, held_code});
            if (inst_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL xfer_extra actual pc=%0d required none", inst_pc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("xfer", {inst_pc, inst_code}, {e.pc, e.code});
                end
                last_xfer_edge = cyc + 1;
                stalled = 1'b0;
            end else begin
                stalled   = 1'b1;
                held_pc   = inst_pc;
                held_code = inst_code;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mem(input int addr, input logic [IW-1:0] data);
        wr_en = 1'b1;
        wr_addr = AW'(addr);
        wr_data = data;
        tick();
        wr_en = 1'b0;
        shadow[addr] = data;
    endtask

    task automatic load_program();
        for (int i = 0; i < 8; i++) write_mem(i, 32'hA0 + i);
    endtask

    task automatic set_cfg(input int mode, input int s0, input int e0, input int c0,
                           input int s1, input int e1, input int c1, input int pend);
        loop_mode  = 2'(mode);
        loop_start = {AW'(0), AW'(s1), AW'(s0)};
        loop_end   = {AW'(63), AW'(e1), AW'(e0)};
        loop_count = {CW'(0), CW'(c1), CW'(c0)};
        prog_end   = AW'(pend);
    endtask

    task automatic start_run(input int pcs[$]);
        foreach (pcs[i]) begin
            exp_t e;
            e.pc = AW'(pcs[i]);
            e.code = shadow[pcs[i]];
            exp_q.push_back(e);
        end
        enable = 1'b1;
    endtask

    // Runs to DONE with a cyclic ready pattern; optional write attempt on cycle wr_cyc.
    task automatic run_prog(input string name, input int pcs[$], input logic [3:0] rdy_pat,
                            input int rdy_len, input int wr_cyc);
        int i;
        bit seen;
        inst_ready = rdy_pat[0];
        start_run(pcs);
        seen = 0;
        for (i = 0; i < 300; i++) begin
            tick();
            inst_ready = rdy_pat[(i + 1) % rdy_len];
            if (i == wr_cyc) begin
                wr_en = 1'b1;
                wr_addr = 6'd3;
                wr_data = 32'hDEAD_BEEF;
            end else begin
                wr_en = 1'b0;
            end
            if (done) begin
                seen = 1;
                break;
            end
        end
        wr_en = 1'b0;
        check({name, "_done_seen"}, 64'(seen), 64'd1);
        check({name, "_done_latency"}, 64'(cyc), 64'(last_xfer_edge));
        check({name, "_all_issued"}, 64'(exp_q.size()), 64'd0);
        check({name, "_valid_in_done"}, 64'(inst_valid), 64'd0);
        exp_q.delete();
        enable = 1'b0;
        tick();
        check({name, "_idle"}, {62'd0, busy, done}, 64'd0);
    endtask

    task automatic check_zero(input string name);
        check({name, "_valid"}, 64'(inst_valid), 64'd0);
        check({name, "_code"}, 64'(inst_code), 64'd0);
        check({name, "_pc"}, 64'(inst_pc), 64'd0);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        #12;
        check_zero("reset");
        rst = 1'b0;
        tick();
        load_program();

        // Loop registers configured but inactive with mode 0.
        set_cfg(0, 1, 2, 3, 0, 0, 0, 4);
        run_prog("linear", '{0, 1, 2, 3, 4}, 4'b0001, 1, -1);

        set_cfg(1, 1, 2, 3, 0, 0, 0, 3);
        run_prog("single", '{0, 1, 2, 1, 2, 1, 2, 3}, 4'b0001, 1, -1);

        set_cfg(2, 2, 3, 2, 1, 3, 2, 3);
        run_prog("nested", '{0, 1, 2, 3, 2, 3, 1, 2, 3, 2, 3}, 4'b0001, 1, -1);

        set_cfg(1, 1, 2, 3, 0, 0, 0, 3);
        run_prog("backpressure", '{0, 1, 2, 1, 2, 1, 2, 3}, 4'b1001, 4, -1);

        // Count 0 runs once; a write attempted mid-run must not reach memory.
        set_cfg(1, 1, 2, 0, 0, 0, 0, 3);
        run_prog("count0", '{0, 1, 2, 3}, 4'b0001, 1, 1);
        set_cfg(0, 0, 0, 0, 0, 0, 0, 4);
        run_prog("readback", '{0, 1, 2, 3, 4}, 4'b0001, 1, -1);

        // Clear mid-loop with enable held, then restart from pc 0 with fresh counters.
        set_cfg(1, 1, 2, 3, 0, 0, 0, 3);
        inst_ready = 1'b1;
        start_run('{0, 1, 2, 1, 2, 1, 2, 3});
        repeat (5) tick();
        clr = 1'b1;
        tick();
        check_zero("clear");
        clr = 1'b0;
        exp_q.delete();
        run_prog("restart", '{0, 1, 2, 1, 2, 1, 2, 3}, 4'b0001, 1, -1);

        // Asynchronous reset mid-loop: outputs drop without waiting for an edge.
        start_run('{0, 1, 2, 1, 2, 1, 2, 3});
        repeat (4) tick();
        #2;
        rst = 1'b1;
        enable = 1'b0;
        #1;
        check_zero("async_rst");
        tick();
        rst = 1'b0;
        exp_q.delete();
        tick();
        load_program();
        run_prog("post_rst", '{0, 1, 2, 1, 2, 1, 2, 3}, 4'b0001, 1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
